// File: rtl/hamming_scrub_pkg.sv
// Shared types and helpers for the Hamming(7,4) scrub controller.
package hamming_scrub_pkg;

  localparam int HAMMING_BLOCK_DATA = 4;
  localparam int HAMMING_BLOCK_PAR  = 3;
  localparam int MAX_BLOCKS         = 32;
  localparam int MAX_PARITY         = MAX_BLOCKS * HAMMING_BLOCK_PAR;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FREEZE,
    SETTLE,
    CHECK,
    CORRECT,
    VERIFY
  } scrub_state_t;

  // Callers zero-extend their syndrome and truncate the mask to their block count.
  function automatic logic [MAX_BLOCKS-1:0] block_err_mask(input logic [MAX_PARITY-1:0] syndrome);
    logic [MAX_BLOCKS-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < MAX_BLOCKS; b++)
      m[b] = |syndrome[b*HAMMING_BLOCK_PAR +: HAMMING_BLOCK_PAR];
    return m;
  endfunction

endpackage

// File: rtl/hamming_scrub_ctrl_timer.sv
// Scrub interval timer: counts enabled cycles, terminal count at PERIOD-1.
module scrub_interval_timer #(
  parameter int PERIOD = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(PERIOD - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_count <= '0;
    else if (i_clr)
      r_count <= '0;
    else if (i_en)
      r_count <= r_count + 1'b1;
  end

  assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/hamming_scrub_ctrl.sv
// Scrub controller for the Hamming(7,4)-protected counter.
// Optional VERIFY pass after correction: define HAMMING_SCRUB_VERIFY_EN.
module hamming_scrub_ctrl
  import hamming_scrub_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int BLOCKS        = WIDTH / HAMMING_BLOCK_DATA,
  parameter int PARITY_BITS   = BLOCKS * HAMMING_BLOCK_PAR,
  parameter int SCRUB_PERIOD  = 256,
  parameter int SETTLE_CYCLES = 2,
  parameter int CORR_CYCLES   = 3,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run_req,
  input  logic                   scrub_req,
  input  logic                   err_clr,
  input  logic [PARITY_BITS-1:0] syndrome,
  output logic                   cnt_en,
  output logic                   scrub_busy,
  output logic                   err_pulse,
  output logic [BLOCKS-1:0]      err_blocks,
  output logic [ERR_CNT_W-1:0]   err_count,
  output logic                   verify_fail
);

  localparam int PH_MAX = (SETTLE_CYCLES > CORR_CYCLES) ? SETTLE_CYCLES : CORR_CYCLES;
  localparam int PH_W   = (PH_MAX > 2) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] CORR_LAST   = PH_W'(CORR_CYCLES - 1);

  scrub_state_t        r_state, w_next, w_exit;
  logic [PH_W-1:0]     r_phase, w_phase_next;
  logic                r_pend;
  logic                w_req;
  logic [BLOCKS-1:0]   w_mask;
  logic                w_err;
  logic                w_tc;
  logic                w_timer_en;
  logic                w_timer_clr;
  logic                w_check_err;
  logic [BLOCKS-1:0]   r_err_blocks;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_mask = BLOCKS'(block_err_mask(MAX_PARITY'(syndrome)));
  assign w_err  = |w_mask;
  assign w_req  = scrub_req | r_pend;

  // A request waiting at scrub end re-enters FREEZE directly so the count never resumes in between.
  assign w_exit = w_req ? FREEZE : (run_req ? RUN : IDLE);

  always_comb begin
    w_next       = r_state;
    w_phase_next = r_phase;
    case (r_state)
      IDLE: begin
        if (w_req)        w_next = FREEZE;
        else if (run_req) w_next = RUN;
      end
      RUN: begin
        if (w_tc || w_req) w_next = FREEZE;
        else if (!run_req) w_next = IDLE;
      end
      FREEZE: begin
        w_next       = SETTLE;
        w_phase_next = '0;
      end
      SETTLE: begin
        if (r_phase == SETTLE_LAST) begin
          w_next       = CHECK;
          w_phase_next = '0;
        end else begin
          w_phase_next = r_phase + 1'b1;
        end
      end
      CHECK: begin
        w_next = w_err ? CORRECT : w_exit;
      end
      CORRECT: begin
        if (r_phase == CORR_LAST) begin
          w_phase_next = '0;
`ifdef HAMMING_SCRUB_VERIFY_EN
          w_next       = VERIFY;
`else
          w_next       = w_exit;
`endif
        end else begin
          w_phase_next = r_phase + 1'b1;
        end
      end
`ifdef HAMMING_SCRUB_VERIFY_EN
      VERIFY: begin
        w_next = w_exit;
      end
`endif
      default: begin
        w_next       = IDLE;
        w_phase_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_phase <= w_phase_next;
      r_pend  <= (w_next == FREEZE) ? 1'b0 : (r_pend | scrub_req);
    end
  end

  assign w_timer_en  = (r_state == RUN);
  assign w_timer_clr = (r_state == RUN) && (w_next == FREEZE);

  scrub_interval_timer #(
    .PERIOD (SCRUB_PERIOD)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_timer_en),
    .i_clr (w_timer_clr),
    .o_tc  (w_tc)
  );

  assign w_check_err = (r_state == CHECK) && w_err;

  // A clear coinciding with CHECK wipes the old history before this scrub's result is recorded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_blocks <= '0;
      r_err_count  <= '0;
    end else if (w_check_err) begin
      r_err_blocks <= (err_clr ? '0 : r_err_blocks) | w_mask;
      if (err_clr)
        r_err_count <= ERR_CNT_W'(1);
      else if (r_err_count != '1)
        r_err_count <= r_err_count + 1'b1;
    end else if (err_clr) begin
      r_err_blocks <= '0;
      r_err_count  <= '0;
    end
  end

`ifdef HAMMING_SCRUB_VERIFY_EN
  logic r_verify_fail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_verify_fail <= 1'b0;
    else if ((r_state == VERIFY) && w_err)
      r_verify_fail <= 1'b1;
    else if (err_clr)
      r_verify_fail <= 1'b0;
  end

  assign verify_fail = r_verify_fail;
`else
  assign verify_fail = 1'b0;
`endif

  assign cnt_en     = (r_state == RUN);
  assign scrub_busy = (r_state != IDLE) && (r_state != RUN);
  assign err_pulse  = w_check_err;
  assign err_blocks = r_err_blocks;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Self-checking bench for hamming_scrub_ctrl: directed scenarios plus random traffic vs a scrub-timeline model.
module tb_hamming_scrub_ctrl;

  localparam int P = 256;
  localparam int S = 2;
  localparam int C = 3;
`ifdef HAMMING_SCRUB_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        run_req, scrub_req, err_clr;
  logic [11:0] syndrome;
  logic        cnt_en, scrub_busy, err_pulse, verify_fail;
  logic [3:0]  err_blocks;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  // model: a scrub is a timeline position k (0 freeze, 1..S settle, S+1 check, then correct/verify)
  bit       m_scrub, m_running, m_pend, m_err_this, m_vf;
  int       m_k, m_timer, m_count;
  bit [3:0] m_blocks;

  logic obs_cnt_en, obs_busy, obs_pulse;

  always #5 clk = ~clk;

  hamming_scrub_ctrl #(
    .WIDTH         (16),
    .SCRUB_PERIOD  (P),
    .SETTLE_CYCLES (S),
    .CORR_CYCLES   (C),
    .ERR_CNT_W     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run_req     (run_req),
    .scrub_req   (scrub_req),
    .err_clr     (err_clr),
    .syndrome    (syndrome),
    .cnt_en      (cnt_en),
    .scrub_busy  (scrub_busy),
    .err_pulse   (err_pulse),
    .err_blocks  (err_blocks),
    .err_count   (err_count),
    .verify_fail (verify_fail)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit [3:0] mask_of(input logic [11:0] syn);
    bit [3:0] m;
    for (int b = 0; b < 4; b++) m[b] = (((syn >> (3 * b)) & 12'h7) != 0);
    return m;
  endfunction

  task automatic model_reset();
    m_scrub = 0; m_running = 0; m_pend = 0; m_err_this = 0; m_vf = 0;
    m_k = 0; m_timer = 0; m_count = 0; m_blocks = '0;
  endtask

  task automatic model_compare();
    bit [3:0] mask;
    mask = mask_of(syndrome);
    check_val("cnt_en",      cnt_en,      {31'd0, (!m_scrub && m_running)});
    check_val("scrub_busy",  scrub_busy,  {31'd0, m_scrub});
    check_val("err_pulse",   err_pulse,   {31'd0, (m_scrub && m_k == S + 1 && mask != 0)});
    check_val("err_blocks",  err_blocks,  {28'd0, m_blocks});
    check_val("err_count",   err_count,   m_count);
    check_val("verify_fail", verify_fail, {31'd0, m_vf});
  endtask

  task automatic model_update();
    bit       req, start;
    bit [3:0] mask;
    int       last;
    req   = scrub_req | m_pend;
    start = 0;
    mask  = mask_of(syndrome);
    if (err_clr) begin
      m_blocks = '0; m_count = 0; m_vf = 0;
    end
    if (!m_scrub) begin
      if (m_running) begin
        m_timer++;
        if (m_timer == P || req) begin
          start = 1; m_timer = 0;
        end else if (!run_req) m_running = 0;
      end else begin
        if (req) start = 1;
        else if (run_req) m_running = 1;
      end
    end else begin
      if (m_k == S + 1) begin
        m_err_this = (mask != 0);
        if (mask != 0) begin
          m_blocks |= mask;
          if (m_count < 255) m_count++;
        end
      end
      if (VER == 1 && m_k == S + 2 + C && mask != 0) m_vf = 1;
      last = m_err_this ? (S + 1 + C + VER) : (S + 1);
      if (m_k == last) begin
        if (req) start = 1;
        else begin
          m_scrub = 0; m_running = run_req;
        end
      end else m_k++;
    end
    if (start) begin
      m_scrub = 1; m_k = 0; m_err_this = 0; m_pend = 0;
    end else m_pend |= scrub_req;
  endtask

  // Called at posedge+1; drives one cycle of inputs, checks at negedge, advances the model.
  task automatic step(input logic rr, input logic sr, input logic ec, input logic [11:0] syn);
    run_req = rr; scrub_req = sr; err_clr = ec; syndrome = syn;
    @(negedge clk);
    obs_cnt_en = cnt_en; obs_busy = scrub_busy; obs_pulse = err_pulse;
    model_compare();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  hi, lo, busy, pulses;
    bit  done;

    rst = 1'b1; run_req = 0; scrub_req = 0; err_clr = 0; syndrome = '0;
    model_reset();
    #1;
    check_val("reset_cnt_en", cnt_en, 0);
    check_val("reset_busy",   scrub_busy, 0);
    check_val("reset_count",  err_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // first automatic scrub after exactly P RUN cycles, 4-cycle clean freeze
    step(1, 0, 0, '0);
    hi = 0; lo = 0; busy = 0; done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      step(1, 0, 0, '0);
      if (obs_cnt_en) hi++;
      else begin lo = 1; busy = obs_busy; done = 1; end
    end
    done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1, 0, 0, '0);
      if (obs_cnt_en) done = 1;
      else begin lo++; busy += obs_busy; end
    end
    check_val("auto_run_len",    hi, P);
    check_val("auto_freeze_len", lo, 4);
    check_val("auto_busy_len",   busy, 4);
    check_val("auto_err_count",  err_count, 0);

    // single-block error found on demand, syndrome held through verify
    step(1, 0, 1, '0);
    step(1, 1, 0, 12'h030);
    lo = 0; pulses = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1, 0, 0, 12'h030);
      if (!obs_cnt_en) begin lo++; pulses += obs_pulse; end
      else if (lo > 0) done = 1;
    end
    check_val("err_freeze_len", lo, 4 + C + VER);
    check_val("err_pulse_cnt",  pulses, 1);
    check_val("err_blocks_030", err_blocks, 4'b0010);
    check_val("err_count_one",  err_count, 1);
    check_val("verify_sticky",  verify_fail, VER);
    step(1, 0, 1, '0);
    step(1, 0, 0, '0);
    check_val("clr_verify", verify_fail, 0);
    check_val("clr_count",  err_count, 0);

    // two requests during one scrub merge into exactly one back-to-back scrub
    lo = 0; done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(1, (i == 0 || i == 2 || i == 4), 0, '0);
      if (i > 0) begin
        if (!obs_cnt_en) lo++;
        else done = 1;
      end
    end
    check_val("merged_freeze_len", lo, 8);

    // saturation of the error counter
    step(1, 0, 1, '0);
    for (int i = 0; i < 2600; i++) step(1, 1, 0, 12'($urandom_range(1, 4095)));
    check_val("err_count_sat", err_count, 8'hFF);
    for (int i = 0; i < 10; i++) step(1, 0, 0, '0);
    step(1, 0, 1, '0);
    step(1, 0, 0, '0);
    check_val("err_count_clr", err_count, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] syn;
      syn = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h000;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 49) == 0, syn);
    end

    // asynchronous reset while correcting
    step(1, 1, 0, 12'h030);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1, 0, 0, 12'h030);
      if (m_scrub && m_k >= S + 2 && m_k <= S + 1 + C) done = 1;
    end
    check_val("reached_correct", done, 1);
    check_val("pre_rst_count",   (err_count != 0), 1);
    #2 rst = 1'b1;
    #1;
    check_val("async_cnt_en", cnt_en, 0);
    check_val("async_busy",   scrub_busy, 0);
    check_val("async_count",  err_count, 0);
    check_val("async_blocks", err_blocks, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 0, 0, '0);
    check_val("post_rst_idle", {obs_cnt_en, obs_busy}, 2'b00);
    for (int i = 0; i < 5; i++) step(1, 0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hamming_scrub_ctrl.md
# hamming_scrub_ctrl

Scrub controller for the Hamming(7,4)-protected event counter. It owns the counter's `enable` input and runs the count normally while the host requests it. Periodically, or on demand, it freezes the count so parity is captured and the syndrome settles, then samples the syndrome and holds the freeze long enough for the correction path to write back. It reports per-block error location, an event count and a verification failure flag to the host.

## Interface
- `WIDTH`, 16, protected counter width; multiple of 4.
- `BLOCKS`, `WIDTH/4`, number of Hamming(7,4) blocks.
- `PARITY_BITS`, `BLOCKS*3`, syndrome width.
- `SCRUB_PERIOD`, 256, RUN cycles between automatic scrubs; ≥ 2.
- `SETTLE_CYCLES`, 2, freeze cycles before the syndrome is sampled; ≥ 1.
- `CORR_CYCLES`, 3, freeze cycles allowed for correction write-back; ≥ 2.
- `ERR_CNT_W`, 8, width of the error event counter.
- `clk`  in  1  clock; all state on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `run_req`  in  1  host level: counting requested.
- `scrub_req`  in  1  single-cycle pulse: request an immediate scrub.
- `err_clr`  in  1  single-cycle pulse: clear `err_count`, `err_blocks` and `verify_fail`.
- `syndrome`  in  `PARITY_BITS`  syndrome from the counter's checker; 3 bits per block.
- `cnt_en`  out  1  enable to the protected counter.
- `scrub_busy`  out  1  high in every state except IDLE and RUN.
- `err_pulse`  out  1  one-cycle pulse when a scrub finds a nonzero syndrome.
- `err_blocks`  out  `BLOCKS`  sticky; bit i set when the syndrome of block i was nonzero.
- `err_count`  out  `ERR_CNT_W`  saturating count of scrubs that found an error.
- `verify_fail`  out  1  sticky; the syndrome was still nonzero after correction.

## Operation
- **Reset values:** all outputs 0, state IDLE, interval timer 0, pending request 0.
- **IDLE**
  - `cnt_en`=0.
  - `run_req`=1 → RUN.
  - `scrub_req` or pending request → FREEZE; this takes priority over `run_req`.
- **RUN**
  - `cnt_en`=1; the timer increments each cycle.
  - `timer==SCRUB_PERIOD-1`, `scrub_req` or pending request → FREEZE; the timer clears.
  - Otherwise `run_req`=0 → IDLE; the timer holds its value.
- **FREEZE:** `cnt_en`=0 for 1 cycle; the counter captures parity on the falling edge of enable.
- **SETTLE:** `cnt_en`=0 for `SETTLE_CYCLES` cycles.
- **CHECK:** 1 cycle; samples `syndrome`.
  - Any 3-bit group nonzero → `err_pulse`=1 this cycle, OR the per-block nonzero mask into `err_blocks`, increment `err_count` (saturating at all-ones), go to CORRECT.
  - Otherwise → exit.
- **CORRECT:** `cnt_en`=0 for `CORR_CYCLES` cycles, then VERIFY (macro defined) or exit.
- **VERIFY:** 1 cycle; any nonzero syndrome group sets `verify_fail`; then exit.
- **Exit:** → RUN if `run_req`=1, otherwise IDLE. There is no cycle with `cnt_en`=1 between FREEZE and exit.
- **`scrub_req` during a scrub:** latched into a one-deep pending flag; further requests merge. The flag is consumed at the next FREEZE entry.
- **`err_clr`:** takes effect the same cycle. If it coincides with CHECK, the clear applies first, so `err_count` becomes 1 and `err_blocks` equals the new mask.
- **`run_req` drop during a scrub:** no effect until exit.
- **Reset mid-scrub:** immediate return to reset values; `cnt_en` falls asynchronously.

## Timing
- Freeze length, no error: 1 + `SETTLE_CYCLES` + 1 = 4 cycles with defaults.
- Freeze length, error: 4 + `CORR_CYCLES` (+1 with VERIFY) = 8 cycles with defaults.
- `scrub_req` in RUN at cycle t:
  - `cnt_en` is low from t+1.
  - CHECK at t+1+`SETTLE_CYCLES`+1.
- `err_pulse`, `err_count` and `err_blocks`: `err_pulse` is high in the CHECK cycle; `err_count` and `err_blocks` update on the edge that ends CHECK.
- Automatic scrub: the first scrub after reset comes after exactly `SCRUB_PERIOD` RUN cycles; the count excludes IDLE cycles.
- `cnt_en` is a registered output (state decode from a flop); no combinational path from any input.

## Configuration
- **`HAMMING_SCRUB_VERIFY_EN` defined:** VERIFY state present; `verify_fail` operates as above.
- **Not defined:** CORRECT exits directly; `verify_fail` is tied to 0; the error freeze shortens by 1 cycle.

## Structure
- **Package `hamming_scrub_pkg`:**
  - `scrub_state_t` enum (IDLE, RUN, FREEZE, SETTLE, CHECK, CORRECT, VERIFY).
  - Function `block_err_mask(syndrome)` returning the per-block OR-reduce.
  - `HAMMING_BLOCK_DATA`=4 and `HAMMING_BLOCK_PAR`=3 constants.
- **Sub-module `scrub_interval_timer`:** the period counter with enable, clear and terminal-count output.
- The FSM and error bookkeeping stay in `hamming_scrub_ctrl`.

## Test plan
- Reset, then `run_req`=1 with `syndrome`=0 → `cnt_en`=1 for 256 cycles, then low for 4 cycles; `err_count`=0; `scrub_busy` is high exactly 4 cycles.
- `scrub_req` pulse in RUN with `syndrome`=12'h030 during CHECK → `err_pulse` 1 cycle, `err_blocks`=4'b0010, `err_count`=1, `cnt_en` low 8 cycles (VERIFY_EN).
- As the previous scenario but `syndrome` stays 12'h030 through VERIFY → `verify_fail`=1 and remains set until `err_clr`.
- 300 forced error scrubs with `ERR_CNT_W`=8 → `err_count` saturates at 8'hFF; then `err_clr` → 0.
- Two `scrub_req` pulses during one scrub → exactly one extra scrub follows immediately; `cnt_en` stays 0 between the two scrubs.
- `rst` asserted in CORRECT → `cnt_en`, `scrub_busy`, `err_count` and `err_blocks` are 0 without a clock edge; next state IDLE.
